button_event_decoder: RTL
=========================

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_CYCLES, default 1_000_000, consecutive high cycles that qualify a long press; legal range >= 2.
REQ-002 Parameter GAP_CYCLES, default 250_000, maximum low cycles between first release and second press for a double click; legal range >= 1.
REQ-003 Parameter REPEAT_CYCLES, default 200_000, auto-repeat interval; legal range >= 1; used only when BTN_REPEAT_EN is defined.
REQ-004 Parameter CNT_W, default 20, counter width; must hold max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES).
REQ-005 Port clk  input  1  single clock; all logic on posedge.
REQ-006 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Port clean_btn  input  1  debounced, synchronous button level, 1 = pressed.
REQ-008 Port press_evt  output  1  one-cycle pulse on every rising edge of clean_btn.
REQ-009 Port release_evt  output  1  one-cycle pulse on every falling edge of clean_btn.
REQ-010 Port short_evt  output  1  one-cycle pulse: single short press confirmed.
REQ-011 Port long_evt  output  1  one-cycle pulse: long press threshold reached.
REQ-012 Port double_evt  output  1  one-cycle pulse: double click confirmed.
REQ-013 Port repeat_evt  output  1  one-cycle auto-repeat pulse while long-held.

Function
REQ-014 All outputs registered; edge detect uses one-cycle delayed btn_q; rise = clean_btn & ~btn_q, fall = ~clean_btn & btn_q.
REQ-015 press_evt/release_evt high for exactly the one cycle beginning at the first edge sampling the new level (1-cycle latency), in every state.
REQ-016 FSM states: IDLE, PRESS1, GAP, PRESS2, LONG_HELD; single counter cnt, cleared on every state change.
REQ-017 IDLE: rise -> PRESS1.
REQ-018 PRESS1: cnt increments per high cycle; on LONG_CYCLES-th consecutive high sample -> long_evt, LONG_HELD; fall earlier -> GAP.
REQ-019 GAP: rise before GAP_CYCLES low samples -> PRESS2; on GAP_CYCLES-th consecutive low sample -> short_evt, IDLE.
REQ-020 PRESS2: fall -> double_evt, IDLE; LONG_CYCLES-th consecutive high sample -> long_evt, LONG_HELD, no double_evt.
REQ-021 LONG_HELD: fall -> IDLE; no short_evt or double_evt ever follows a long_evt for the same press.
REQ-022 At most one of short_evt, long_evt, double_evt high in any cycle; each press sequence yields exactly one of them.
REQ-023 Counter saturates, never wraps; comparisons full CNT_W width, unsigned.
REQ-024 Rise and fall cannot coexist in one cycle; clean_btn toggling every cycle follows the transitions above without lost edges.

Reset
REQ-025 reset_n low: state IDLE, cnt 0, btn_q 0, all outputs 0, asynchronously.
REQ-026 Reset mid-sequence discards the sequence; no event pulse emitted on or after release of reset until a new rise.
REQ-027 clean_btn high when reset releases: no press_evt; first event is release_evt on the subsequent fall, FSM stays IDLE.

Configuration
REQ-028 Macro BTN_REPEAT_EN: when defined, in LONG_HELD repeat_evt pulses every REPEAT_CYCLES high cycles after long_evt (first pulse REPEAT_CYCLES after long_evt) until fall.
REQ-029 BTN_REPEAT_EN undefined: repeat_evt tied 0, no repeat counter logic.

Structure
REQ-030 Package btn_pkg holds the state enum type btn_state_t and default timing constants.
REQ-031 Sub-module btn_edge_det (btn_q register, rise/fall) instantiated once; FSM and counter in top.

Verification (LONG=8, GAP=4, REPEAT=3)
REQ-032 Hold high 3 cycles, release, stay low 4 cycles -> press_evt, release_evt, then short_evt on 4th low sample; no long/double.
REQ-033 High 3, low 2, high 3, low -> double_evt at release of second press; no short_evt.
REQ-034 Hold high 14 cycles -> long_evt on 8th high sample; with BTN_REPEAT_EN repeat_evt at high samples 11 and 14; without, none; release -> release_evt only.
REQ-035 High 3, low 4 exactly then rise -> short_evt on 4th low sample, new sequence starts in PRESS1.
REQ-036 reset_n pulsed low during PRESS2 -> all outputs 0 immediately, no double_evt after release with clean_btn low.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing for the button event decoder.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG_HELD
    } btn_state_t;

    localparam int unsigned DEF_LONG_CYCLES   = 1_000_000;
    localparam int unsigned DEF_GAP_CYCLES    = 250_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 200_000;
    localparam int unsigned DEF_CNT_W         = 20;

endpackage

// File: rtl/btn_edge_det.sv
// Registers the button level and flags rising/falling edges against the previous sample.
module btn_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic btn_q;
    logic primed;

    // The first sample after reset only seeds btn_q, so a button already held at release reports no press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q  <= 1'b0;
            primed <= 1'b0;
        end else begin
            btn_q  <= level;
            primed <= 1'b1;
        end
    end

    assign rise = primed & level & ~btn_q;
    assign fall = primed & ~level & btn_q;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a clean button level into press/release, short, long and double-click pulses.
// Optional auto-repeat while long-held is enabled by defining BTN_REPEAT_EN.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clean_btn,
    output logic press_evt,
    output logic release_evt,
    output logic short_evt,
    output logic long_evt,
    output logic double_evt,
    output logic repeat_evt
);

    localparam longint unsigned MAX_CYCLES =
        (LONG_CYCLES > GAP_CYCLES)
            ? ((LONG_CYCLES > REPEAT_CYCLES) ? longint'(LONG_CYCLES) : longint'(REPEAT_CYCLES))
            : ((GAP_CYCLES > REPEAT_CYCLES) ? longint'(GAP_CYCLES) : longint'(REPEAT_CYCLES));

    if ((MAX_CYCLES >> CNT_W) != 0) begin : g_cnt_w_check
        $error("button_event_decoder: CNT_W cannot hold the largest cycle count");
    end

    // The edge sample itself counts as the first high/low sample, hence the -2 offsets.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    logic rise;
    logic fall;

    btn_state_t       state;
    btn_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             short_n;
    logic             long_n;
    logic             double_n;

    btn_edge_det u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (clean_btn),
        .rise    (rise),
        .fall    (fall)
    );

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic repeat_n;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt_inc;
        short_n  = 1'b0;
        long_n   = 1'b0;
        double_n = 1'b0;
`ifdef BTN_REPEAT_EN
        repeat_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rise) state_n = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    if (GAP_CYCLES == 1) begin
                        short_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = GAP;
                    end
                end else if (cnt == LONG_LAST) begin
                    long_n  = 1'b1;
                    state_n = LONG_HELD;
                end
            end
            GAP: begin
                if (rise) begin
                    state_n = PRESS2;
                end else if (cnt == GAP_LAST) begin
                    short_n = 1'b1;
                    state_n = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_n = 1'b1;
                    state_n  = IDLE;
                end else if (cnt == LONG_LAST) begin
                    long_n  = 1'b1;
                    state_n = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_n = IDLE;
                end
`ifdef BTN_REPEAT_EN
                else if (cnt == REP_LAST) begin
                    repeat_n = 1'b1;
                    cnt_n    = '0;
                end
`else
                else begin
                    cnt_n = '0;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state) cnt_n = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            short_evt   <= 1'b0;
            long_evt    <= 1'b0;
            double_evt  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            press_evt   <= rise;
            release_evt <= fall;
            short_evt   <= short_n;
            long_evt    <= long_n;
            double_evt  <= double_n;
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) repeat_evt <= 1'b0;
        else          repeat_evt <= repeat_n;
    end
`else
    assign repeat_evt = 1'b0;
`endif

endmodule
